// File: rtl/otter_mem_responder.sv
// otter_mem_responder
// Memory responder for the OTTER core: one single-ported word array shared by
// the instruction-fetch port and the data port, an I/O window at and above
// IO_BASE, configurable wait states, and fetch-first arbitration.
//
// Parameters:
//   ADDR_W      word-address width of the array (2**ADDR_W 32-bit words)
//   WAIT_STATES extra cycles per access (0-15)
//   IO_BASE     first byte address routed to the I/O bus
// Ports:
//   clk, RST               clock, asynchronous active-high reset
//   memRDEN1/memADDR1      fetch request pulse and word address
//   memRDEN2/memWE2        data read / write request pulses
//   memADDR2/memDIN2       data byte address and right-justified store data
//   memSIZE2/memSIGN2      access size (00 b, 01 h, 1x w) and 1 = zero-extend
//   memDOUT1/memDOUT2      registered fetch data and extended load data
//   memBUSY                registered stall, requests ignored while high
//   memERR                 one-cycle misaligned-access pulse
//   IOBUS_IN/ADDR/OUT/WR   memory-mapped I/O bus

module otter_mem_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              memRDEN1,
  input  logic [ADDR_W-1:0] memADDR1,
  input  logic              memRDEN2,
  input  logic              memWE2,
  input  logic [31:0]       memADDR2,
  input  logic [31:0]       memDIN2,
  input  logic [1:0]        memSIZE2,
  input  logic              memSIGN2,
  output logic [31:0]       memDOUT1,
  output logic [31:0]       memDOUT2,
  output logic              memBUSY,
  output logic              memERR,
  input  logic [31:0]       IOBUS_IN,
  output logic [31:0]       IOBUS_ADDR,
  output logic [31:0]       IOBUS_OUT,
  output logic              IOBUS_WR
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SERVE2 = 2'd2
  } state_t;

  // Word storage (contents are intentionally not reset)
  logic [31:0] r_mem [DEPTH];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_done;
  logic               r_busy;

  // Latched request
  logic               r_fpend;
  logic               r_dpend;
  logic               r_rd;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_faddr;
  logic [31:0]        r_addr;
  logic [31:0]        r_din;
  logic [1:0]         r_size;
  logic               r_sign;

  // Registered outputs
  logic [31:0]        r_dout1;
  logic [31:0]        r_dout2;
  logic               r_err;
  logic [31:0]        r_io_addr;
  logic [31:0]        r_io_out;
  logic               r_io_wr;

  // Active request view: live inputs in IDLE, latched copy otherwise
  logic               w_idle;
  logic               w_req;
  logic               w_accept;
  logic               w_fetch;
  logic               w_dreq;
  logic               w_rd;
  logic               w_wr;
  logic [ADDR_W-1:0]  w_faddr;
  logic [31:0]        w_addr;
  logic [31:0]        w_din;
  logic [1:0]         w_size;
  logic               w_sign;

  logic               w_fdone;
  logic               w_ddone;
  logic               w_io;
  logic               w_mis;
  logic [ADDR_W-1:0]  w_daddr;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [31:0]        w_mem_rdata;
  logic               w_mem_we;
  logic [3:0]         w_be;
  logic [31:0]        w_wsh;
  logic [31:0]        w_wdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;

  assign w_idle   = (r_state == IDLE);
  assign w_req    = memRDEN1 | memRDEN2 | memWE2;
  assign w_accept = w_idle & w_req;

  assign w_fetch  = w_idle ? memRDEN1             : r_fpend;
  assign w_dreq   = w_idle ? (memRDEN2 | memWE2)  : r_dpend;
  assign w_rd     = w_idle ? memRDEN2             : r_rd;
  assign w_wr     = w_idle ? memWE2               : r_wr;
  assign w_faddr  = w_idle ? memADDR1             : r_faddr;
  assign w_addr   = w_idle ? memADDR2             : r_addr;
  assign w_din    = w_idle ? memDIN2              : r_din;
  assign w_size   = w_idle ? memSIZE2             : r_size;
  assign w_sign   = w_idle ? memSIGN2             : r_sign;

  // Fetch always completes before a pending data access
  assign w_fdone  = w_done & w_fetch;
  assign w_ddone  = w_done & ~w_fetch & w_dreq;

  assign w_io     = (w_addr >= IO_BASE);
  assign w_mis    = ~w_io & (((w_size == 2'b01) & w_addr[0]) |
                             (w_size[1] & (w_addr[1:0] != 2'b00)));
  assign w_daddr  = w_addr[ADDR_W+1:2];

  // Single array port: fetch owns it while a fetch is the active access
  assign w_mem_addr  = w_fetch ? w_faddr : w_daddr;
  assign w_mem_rdata = r_mem[w_mem_addr];

  // Write is gated by RST so an access racing a reset never lands
  assign w_mem_we = w_ddone & w_wr & ~w_io & ~w_mis & ~RST;

  // Next-state, wait counter and completion detect
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_done = 1'b1;
            if (memRDEN1 && (memRDEN2 || memWE2)) begin
              w_state_nxt = SERVE2;
            end
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_done      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = (r_fpend && r_dpend) ? SERVE2 : IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      SERVE2: begin
        if (WAIT_STATES == 0) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_W'(WAIT_STATES);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counter and stall register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Store data lane steering and byte enables
  always_comb begin
    w_be  = 4'b1111;
    w_wsh = w_din;
    case (w_size)
      2'b00: begin
        w_be  = 4'b0001 << w_addr[1:0];
        w_wsh = {4{w_din[7:0]}};
      end
      2'b01: begin
        w_be  = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wsh = {2{w_din[15:0]}};
      end
      default: begin
        w_be  = 4'b1111;
        w_wsh = w_din;
      end
    endcase
    w_wdata = w_mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        w_wdata[i*8 +: 8] = w_wsh[i*8 +: 8];
      end
    end
  end

  // Load lane extraction and extension (memSIGN2 = 1 zero-extends)
  always_comb begin
    case (w_addr[1:0])
      2'b00:   w_byte = w_mem_rdata[7:0];
      2'b01:   w_byte = w_mem_rdata[15:8];
      2'b10:   w_byte = w_mem_rdata[23:16];
      default: w_byte = w_mem_rdata[31:24];
    endcase
    w_half = w_addr[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];
    case (w_size)
      2'b00:   w_load = w_sign ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = w_sign ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_mem_rdata;
    endcase
  end

  // Array write port
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_daddr] <= w_wdata;
    end
  end

  // Request latch and registered responses
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_fpend   <= 1'b0;
      r_dpend   <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_faddr   <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_size    <= '0;
      r_sign    <= 1'b0;
      r_dout1   <= '0;
      r_dout2   <= '0;
      r_err     <= 1'b0;
      r_io_addr <= '0;
      r_io_out  <= '0;
      r_io_wr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fpend <= memRDEN1;
        r_dpend <= memRDEN2 | memWE2;
        r_rd    <= memRDEN2;
        r_wr    <= memWE2;
        r_faddr <= memADDR1;
        r_addr  <= memADDR2;
        r_din   <= memDIN2;
        r_size  <= memSIZE2;
        r_sign  <= memSIGN2;
      end
      // I/O address is presented as soon as a data access to the window is taken
      if (w_accept && (memRDEN2 || memWE2) && (memADDR2 >= IO_BASE)) begin
        r_io_addr <= memADDR2;
      end
      if (w_fdone) begin
        r_fpend <= 1'b0;
        r_dout1 <= w_mem_rdata;
      end
      if (w_ddone) begin
        r_dpend <= 1'b0;
        if (w_rd) begin
          if (w_io) begin
            r_dout2 <= IOBUS_IN;
          end else if (w_mis) begin
            r_dout2 <= '0;
          end else begin
            r_dout2 <= w_load;
          end
        end
        if (w_wr && w_io) begin
          r_io_addr <= w_addr;
          r_io_out  <= w_din;
        end
      end
      r_err   <= w_ddone & w_mis;
      r_io_wr <= w_ddone & w_wr & w_io;
    end
  end

  assign memDOUT1   = r_dout1;
  assign memDOUT2   = r_dout2;
  assign memBUSY    = r_busy;
  assign memERR     = r_err;
  assign IOBUS_ADDR = r_io_addr;
  assign IOBUS_OUT  = r_io_out;
  assign IOBUS_WR   = r_io_wr;

endmodule

// File: tb/tb_otter_mem_responder.sv
// Directed bench for otter_mem_responder. Three instances share the stimulus:
// index 0 has WAIT_STATES=0, index 1 has 2, index 2 has 3. Inputs change and
// outputs are sampled on the falling edge.

module tb_otter_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rden1;
  logic [13:0] addr1;
  logic        rden2;
  logic        we2;
  logic [31:0] addr2;
  logic [31:0] din2;
  logic [1:0]  size2;
  logic        sign2;
  logic [31:0] iobus_in;

  logic [31:0] dout1  [3];
  logic [31:0] dout2  [3];
  logic [31:0] ioaddr [3];
  logic [31:0] ioout  [3];
  logic        busy   [3];
  logic        err    [3];
  logic        iowr   [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    otter_mem_responder #(
      .ADDR_W      (14),
      .WAIT_STATES ((g == 0) ? 0 : g + 1),
      .IO_BASE     (32'h1100_0000)
    ) u_dut (
      .clk        (clk),
      .RST        (rst),
      .memRDEN1   (rden1),
      .memADDR1   (addr1),
      .memRDEN2   (rden2),
      .memWE2     (we2),
      .memADDR2   (addr2),
      .memDIN2    (din2),
      .memSIZE2   (size2),
      .memSIGN2   (sign2),
      .memDOUT1   (dout1[g]),
      .memDOUT2   (dout2[g]),
      .memBUSY    (busy[g]),
      .memERR     (err[g]),
      .IOBUS_IN   (iobus_in),
      .IOBUS_ADDR (ioaddr[g]),
      .IOBUS_OUT  (ioout[g]),
      .IOBUS_WR   (iowr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a one-cycle data request; returns in the cycle after the request edge
  task automatic data_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic sg);
    we2   = wr;
    rden2 = ~wr;
    addr2 = a;
    din2  = d;
    size2 = sz;
    sign2 = sg;
    @(negedge clk);
    we2   = 1'b0;
    rden2 = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rden1    = 1'b0;
    addr1    = '0;
    rden2    = 1'b0;
    we2      = 1'b0;
    addr2    = '0;
    din2     = '0;
    size2    = 2'b10;
    sign2    = 1'b0;
    iobus_in = 32'hA5A5_5A5A;
    cycles(2);

    check ("rst_dout1",  dout1[0],  32'h0);
    check ("rst_dout2",  dout2[0],  32'h0);
    check1("rst_busy",   busy[0],   1'b0);
    check1("rst_err",    err[0],    1'b0);
    check1("rst_iowr",   iowr[0],   1'b0);
    check ("rst_ioaddr", ioaddr[0], 32'h0);
    check ("rst_ioout",  ioout[0],  32'h0);
    check1("rst_busy_ws3", busy[2], 1'b0);
    rst = 1'b0;
    cycles(1);

    // Reset mid-wait (WAIT_STATES=3): the aborted store must not land
    data_req(1'b1, 32'h200, 32'h1122_3344, 2'b10, 1'b0);
    cycles(10);
    data_req(1'b1, 32'h200, 32'hCAFE_F00D, 2'b10, 1'b0);
    check1("ws3_busy_p1", busy[2], 1'b1);
    cycles(1);
    rst = 1'b1;
    #1;
    check1("ws3_rst_busy", busy[2],  1'b0);
    check ("ws3_rst_dout2", dout2[2], 32'h0);
    check1("ws3_rst_iowr", iowr[2],  1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
    data_req(1'b0, 32'h200, 32'h0, 2'b10, 1'b0);
    check1("ws3_accept_busy", busy[2], 1'b1);
    cycles(2);
    check1("ws3_busy_p3", busy[2], 1'b1);
    cycles(1);
    check ("ws3_no_write", dout2[2], 32'h1122_3344);
    check1("ws3_busy_p4",  busy[2],  1'b0);
    cycles(10);

    // Word store then load, no wait states
    data_req(1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0);
    check1("sw_busy", busy[0], 1'b0);
    cycles(10);
    data_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    check ("lw_100",  dout2[0], 32'hDEAD_BEEF);
    check1("lw_busy", busy[0],  1'b0);
    cycles(10);

    // Byte store uses only the low byte of the store data
    data_req(1'b1, 32'h103, 32'h1234_5680, 2'b00, 1'b0);
    cycles(10);
    data_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b0);
    check("lb_103", dout2[0], 32'hFFFF_FF80);
    cycles(10);
    data_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b1);
    check("lbu_103", dout2[0], 32'h0000_0080);
    cycles(10);
    data_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    check("lw_after_sb", dout2[0], 32'h80AD_BEEF);
    cycles(10);
    data_req(1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
    check("lh_102", dout2[0], 32'hFFFF_80AD);
    cycles(10);
    data_req(1'b0, 32'h100, 32'h0, 2'b01, 1'b1);
    check("lhu_100", dout2[0], 32'h0000_BEEF);
    cycles(10);

    // Fetch/data collision: fetch first, data one cycle later
    data_req(1'b1, 32'h004, 32'h0040_0093, 2'b10, 1'b0);
    cycles(10);
    rden1 = 1'b1;
    addr1 = 14'd1;
    rden2 = 1'b1;
    addr2 = 32'h100;
    size2 = 2'b10;
    sign2 = 1'b0;
    @(negedge clk);
    rden1 = 1'b0;
    rden2 = 1'b0;
    check ("col_dout1_p1", dout1[0], 32'h0040_0093);
    check1("col_busy_p1",  busy[0],  1'b1);
    check ("col_dout2_hold", dout2[0], 32'h0000_BEEF);
    cycles(1);
    check ("col_dout2_p2", dout2[0], 32'h80AD_BEEF);
    check1("col_busy_p2",  busy[0],  1'b0);
    cycles(10);

    // Misaligned accesses
    data_req(1'b0, 32'h101, 32'h0, 2'b01, 1'b0);
    check ("mis_lh_dout2", dout2[0], 32'h0);
    check1("mis_lh_err",   err[0],   1'b1);
    cycles(1);
    check1("mis_lh_err_end", err[0], 1'b0);
    cycles(10);
    data_req(1'b1, 32'h102, 32'hFFFF_FFFF, 2'b10, 1'b0);
    check1("mis_sw_err", err[0], 1'b1);
    cycles(10);
    data_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    check("mis_sw_unchanged", dout2[0], 32'h80AD_BEEF);
    cycles(10);

    // I/O write with two wait states
    data_req(1'b1, 32'h1100_0000, 32'h0000_0055, 2'b00, 1'b0);
    check1("io_busy_p1", busy[1], 1'b1);
    check1("io_wr_p1",   iowr[1], 1'b0);
    cycles(1);
    check1("io_busy_p2", busy[1], 1'b1);
    check1("io_wr_p2",   iowr[1], 1'b0);
    cycles(1);
    check1("io_busy_p3", busy[1],   1'b0);
    check1("io_wr_p3",   iowr[1],   1'b1);
    check ("io_out_p3",  ioout[1],  32'h0000_0055);
    check ("io_addr_p3", ioaddr[1], 32'h1100_0000);
    cycles(1);
    check1("io_wr_p4", iowr[1], 1'b0);
    cycles(10);

    // I/O read returns the full bus word regardless of size
    data_req(1'b0, 32'h1100_0004, 32'h0, 2'b00, 1'b0);
    check("io_rd_addr_p1", ioaddr[1], 32'h1100_0004);
    check("io_rd_ws0",     dout2[0],  32'hA5A5_5A5A);
    cycles(2);
    check("io_rd_ws2",     dout2[1],  32'hA5A5_5A5A);
    cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_mem_responder.md
# otter_mem_responder

Memory responder for the OTTER RISC-V core. It services the control unit's instruction-fetch port (memRDEN1) and data port (memRDEN2/memWE2) from one internal single-ported word array. It also decodes a memory-mapped I/O window. It adds configurable wait states, arbitrates simultaneous fetch and data requests, and reports stalls and misaligned accesses back to the datapath.

## Interface
- ADDR_W, 14: word-address width of the internal array (2**ADDR_W 32-bit words)
- WAIT_STATES, 0: extra cycles per access (0-15)
- IO_BASE, 32'h1100_0000: byte addresses >= IO_BASE go to the I/O bus, not the array
- clk  in  1  system clock, all state on rising edge
- RST  in  1  reset; asynchronous, active-high
- memRDEN1  in  1  fetch read request (one-cycle pulse)
- memADDR1  in  ADDR_W  fetch word address (PC[ADDR_W+1:2])
- memRDEN2  in  1  data read request (one-cycle pulse)
- memWE2  in  1  data write request (one-cycle pulse); never high together with memRDEN2
- memADDR2  in  32  data byte address
- memDIN2  in  32  store data, right-justified
- memSIZE2  in  2  00 byte, 01 half, 10 word; 11 treated as word
- memSIGN2  in  1  1 = zero-extend loads, 0 = sign-extend
- memDOUT1  out  32  fetch data
- memDOUT2  out  32  load data, extended to 32 bits
- memBUSY  out  1  responder stall; requests are ignored while high
- memERR  out  1  one-cycle pulse for a misaligned data access
- IOBUS_IN  in  32  I/O read data
- IOBUS_ADDR  out  32  I/O byte address
- IOBUS_OUT  out  32  I/O write data
- IOBUS_WR  out  1  one-cycle I/O write strobe

## Operation
- FSM states: IDLE, WAIT, SERVE2.
- IDLE: requests present at a rising edge are latched (addresses, data, size, sign).
  - WAIT_STATES=0: the access completes on that edge.
  - WAIT_STATES>0: the FSM goes to WAIT with the counter loaded to WAIT_STATES.
- WAIT: the counter decrements each cycle. The access completes on the edge where the counter reaches 0. The FSM then returns to IDLE, or goes to SERVE2 if a data request is pending.
- Fetch and data requests in the same cycle: fetch is serviced first. The data access is held pending, then runs through SERVE2 (plus WAIT_STATES cycles).
- Array reads: the addressed word is registered into memDOUT1, or extracted into memDOUT2.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Loads are extended per memSIGN2.
- Array writes: only the byte lanes selected by size and addr[1:0] are updated, using the low bits of memDIN2.
- I/O window (memADDR2 >= IO_BASE):
  - Writes: IOBUS_WR pulses for one cycle on completion, with IOBUS_ADDR=memADDR2 and IOBUS_OUT=memDIN2 (full word, size ignored). The array is not touched.
  - Reads: IOBUS_ADDR is driven while the access is pending. memDOUT2 = IOBUS_IN sampled at the completing edge (full word, size ignored).
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0, to the array.
  - No array write occurs; a read returns 0.
  - memERR pulses for one cycle at completion.
  - Latency is unchanged.
- Array address: memADDR2[ADDR_W+1:2]. Higher address bits below IO_BASE alias (wrap-around).
- memDOUT1 and memDOUT2 hold their last value until the next completion on that port.

## Timing
- Reset: memDOUT1=0, memDOUT2=0, memBUSY=0, memERR=0, IOBUS_WR=0, IOBUS_ADDR=0, IOBUS_OUT=0; FSM returns to IDLE; any pending request is discarded. Array contents are not reset.
- Reset asserted mid-access: the access is aborted, with no partial write and no IOBUS_WR.
- Single access latency: data is valid in the cycle after the request edge plus WAIT_STATES cycles (total 1+WAIT_STATES).
- memBUSY is registered. It is high from the cycle after the request edge through the cycle before the completing edge. It is never high for a single access with WAIT_STATES=0.
- Collision with WAIT_STATES=0:
  - memDOUT1 is valid at cycle +1, with memBUSY=1 in that same cycle.
  - memDOUT2 is valid, or the write is applied, at cycle +2.
- Requests arriving while memBUSY=1 are dropped silently; the CU must not issue them.
- Read-after-write to the same word in consecutive accesses returns the new data; there is no bypass requirement beyond sequential ordering.

## Test plan
- Reset mid-wait (WAIT_STATES=3): request, assert RST at cycle +2 -> all outputs 0, no write observed, FSM idle at next request.
- Word store 0xDEADBEEF at 0x100, load word 0x100 (WAIT_STATES=0) -> memDOUT2=0xDEADBEEF one cycle after the load pulse, memBUSY never high.
- Store byte 0x80 at 0x103, then load byte signed and unsigned at 0x103 -> 0xFFFFFF80 and 0x00000080; word at 0x100 = 0x80ADBEEF.
- Simultaneous memRDEN1 (addr 4) and memRDEN2 (0x100) -> memDOUT1 at +1 with memBUSY=1, memDOUT2=0x80ADBEEF at +2.
- Half load at 0x101 -> memERR one-cycle pulse, memDOUT2=0; word store at 0x102 -> array unchanged.
- Store 0x55 to 0x1100_0000 with WAIT_STATES=2 -> memBUSY high 2 cycles, IOBUS_WR one pulse at cycle +3 with IOBUS_OUT=0x55; load from 0x1100_0004 returns IOBUS_IN.
